// File: rtl/costas_lock_ctrl_if.sv
// Costas lock controller bus: phase-error input stream plus loop-filter/NCO control outputs.
// The master drives the error stream and enable; the slave (the controller) drives the controls.
interface costas_lock_ctrl_if;
  logic               enable;
  logic               err_valid;
  logic signed [27:0] err;
  logic               lf_ce;
  logic               lf_clr;
  logic        [4:0]  kp_shift;
  logic        [4:0]  ki_shift;
  logic               locked;
  logic        [1:0]  state;
  logic signed [31:0] freq_offset;

  modport master (
    output enable, err_valid, err,
    input  lf_ce, lf_clr, kp_shift, ki_shift, locked, state, freq_offset
  );

  modport slave (
    input  enable, err_valid, err,
    output lf_ce, lf_clr, kp_shift, ki_shift, locked, state, freq_offset
  );
endinterface

// File: rtl/costas_lock_ctrl.sv
// Costas loop lock-acquisition sequencer.
// Watches the phase-error stream, gates the loop-filter clock enable, selects acquisition or
// tracking gain shifts, declares lock and clears/restarts the filter on timeout or loss of lock.
// Optional feature: define COSTAS_FREQ_SWEEP_EN to step freq_offset on every acquisition timeout;
// without it freq_offset is tied to zero and no sweep logic exists.
module costas_lock_ctrl #(
  parameter logic [4:0]  KP_ACQ      = 5'd6,
  parameter logic [4:0]  KI_ACQ      = 5'd13,
  parameter logic [4:0]  KP_TRK      = 5'd9,
  parameter logic [4:0]  KI_TRK      = 5'd17,
  parameter logic [27:0] LOCK_THR    = 28'd200000,
  parameter logic [27:0] UNLOCK_THR  = 28'd800000,
  parameter logic [15:0] LOCK_CNT    = 16'd64,
  parameter logic [15:0] UNLOCK_CNT  = 16'd16,
  parameter logic [15:0] ACQ_TIMEOUT = 16'd4096,
  parameter logic [3:0]  CLR_CYCLES  = 4'd4
`ifdef COSTAS_FREQ_SWEEP_EN
  ,
  parameter logic signed [31:0] SWEEP_STEP = 32'sh0010_0000,
  parameter logic signed [31:0] SWEEP_MAX  = 32'sh0080_0000
`endif
) (
  input logic             clk,
  input logic             rst,
  costas_lock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQ     = 2'd1,
    ST_TRACK   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] good_cnt_r;
  logic [15:0] good_cnt_s;
  logic [15:0] bad_cnt_r;
  logic [15:0] bad_cnt_s;
  logic [15:0] timeout_cnt_r;
  logic [15:0] timeout_cnt_s;
  logic [3:0]  clr_cnt_r;
  logic        lf_clr_r;
  logic        locked_r;
  logic [4:0]  kp_r;
  logic [4:0]  ki_r;
  logic [27:0] mag_s;
  logic        good_s;
  logic        bad_s;

  // Magnitude of a signed error; the most negative code has no positive twin, so it saturates.
  function automatic logic [27:0] abs_sat(input logic signed [27:0] v);
    logic [27:0] r;
    if (v == 28'sh800_0000) begin
      r = 28'h7FF_FFFF;
    end else if (v[27]) begin
      r = 28'(-v);
    end else begin
      r = 28'(v);
    end
    return r;
  endfunction

  // Saturating increment so long runs never wrap back to zero.
  function automatic logic [15:0] inc_sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign bus.lf_ce    = bus.err_valid & ((state_r == ST_ACQ) | (state_r == ST_TRACK));
  assign bus.lf_clr   = lf_clr_r;
  assign bus.locked   = locked_r;
  assign bus.kp_shift = kp_r;
  assign bus.ki_shift = ki_r;
  assign bus.state    = state_r;

  // Classify the current sample and compute next state and next counter values.
  always_comb begin
    mag_s         = abs_sat(bus.err);
    good_s        = (mag_s < LOCK_THR);
    bad_s         = (mag_s >= UNLOCK_THR);
    state_s       = state_r;
    good_cnt_s    = good_cnt_r;
    bad_cnt_s     = bad_cnt_r;
    timeout_cnt_s = timeout_cnt_r;
    if (!bus.enable) begin
      state_s       = ST_IDLE;
      good_cnt_s    = 16'd0;
      bad_cnt_s     = 16'd0;
      timeout_cnt_s = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Always clear the filter before the first acquisition attempt.
          state_s       = ST_RECOVER;
          good_cnt_s    = 16'd0;
          bad_cnt_s     = 16'd0;
          timeout_cnt_s = 16'd0;
        end
        ST_RECOVER: begin
          good_cnt_s    = 16'd0;
          bad_cnt_s     = 16'd0;
          timeout_cnt_s = 16'd0;
          if (clr_cnt_r >= (CLR_CYCLES - 4'd1)) begin
            state_s = ST_ACQ;
          end else begin
            state_s = ST_RECOVER;
          end
        end
        ST_ACQ: begin
          if (bus.err_valid) begin
            timeout_cnt_s = inc_sat16(timeout_cnt_r);
            good_cnt_s    = good_s ? inc_sat16(good_cnt_r) : 16'd0;
            // Lock is tested first so it wins over a timeout on the same sample.
            if (good_cnt_s >= LOCK_CNT) begin
              state_s   = ST_TRACK;
              bad_cnt_s = 16'd0;
            end else if (timeout_cnt_s >= ACQ_TIMEOUT) begin
              state_s = ST_RECOVER;
            end else begin
              state_s = ST_ACQ;
            end
          end else begin
            state_s = ST_ACQ;
          end
        end
        ST_TRACK: begin
          if (bus.err_valid) begin
            // Mid-band samples are not bad, so they restart the run (hysteresis).
            bad_cnt_s = bad_s ? inc_sat16(bad_cnt_r) : 16'd0;
            if (bad_cnt_s >= UNLOCK_CNT) begin
              state_s = ST_RECOVER;
            end else begin
              state_s = ST_TRACK;
            end
          end else begin
            state_s = ST_TRACK;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered control outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      good_cnt_r    <= 16'd0;
      bad_cnt_r     <= 16'd0;
      timeout_cnt_r <= 16'd0;
      clr_cnt_r     <= 4'd0;
      lf_clr_r      <= 1'b0;
      locked_r      <= 1'b0;
      kp_r          <= KP_ACQ;
      ki_r          <= KI_ACQ;
    end else begin
      state_r       <= state_s;
      good_cnt_r    <= good_cnt_s;
      bad_cnt_r     <= bad_cnt_s;
      timeout_cnt_r <= timeout_cnt_s;
      clr_cnt_r     <= ((state_r == ST_RECOVER) && (state_s == ST_RECOVER) && (clr_cnt_r != 4'hF))
                       ? clr_cnt_r + 4'd1 : 4'd0;
      lf_clr_r      <= (state_s == ST_RECOVER);
      locked_r      <= (state_s == ST_TRACK);
      kp_r          <= (state_s == ST_TRACK) ? KP_TRK : KP_ACQ;
      ki_r          <= (state_s == ST_TRACK) ? KI_TRK : KI_ACQ;
    end
  end

`ifdef COSTAS_FREQ_SWEEP_EN
  logic signed [31:0] freq_offset_r;

  // Next sweep point; stepping past the positive limit wraps to the negative limit.
  function automatic logic signed [31:0] sweep_next(input logic signed [31:0] fo);
    logic signed [31:0] sum;
    sum = fo + SWEEP_STEP;
    if (sum > SWEEP_MAX) begin
      return -SWEEP_MAX;
    end else begin
      return sum;
    end
  endfunction

  // Step the NCO offset on an acquisition timeout (the only ACQ->RECOVER path); IDLE clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_offset_r <= 32'sd0;
    end else if (state_s == ST_IDLE) begin
      freq_offset_r <= 32'sd0;
    end else if ((state_r == ST_ACQ) && (state_s == ST_RECOVER)) begin
      freq_offset_r <= sweep_next(freq_offset_r);
    end else begin
      freq_offset_r <= freq_offset_r;
    end
  end

  assign bus.freq_offset = freq_offset_r;
`else
  assign bus.freq_offset = 32'sd0;
`endif

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed self-checking bench for costas_lock_ctrl with a queue-based scoreboard.
// Build with COSTAS_FREQ_SWEEP_EN defined to also exercise the frequency sweep and its wrap.
module tb_costas_lock_ctrl;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_TRK  = 2'd2;
  localparam logic [1:0] S_REC  = 2'd3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  costas_lock_ctrl_if bus ();

  costas_lock_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_fo   = 32'd0;
  int          clr_seen;
  int          n_timeouts;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Expected {state, locked, lf_clr, kp, ki, freq_offset} for a given state.
  function automatic logic [63:0] st_word(input logic [1:0] st, input logic [31:0] fo);
    logic       trk;
    logic [4:0] kp;
    logic [4:0] ki;
    trk = (st == S_TRK);
    kp  = trk ? 5'd9 : 5'd6;
    ki  = trk ? 5'd17 : 5'd13;
    return {18'd0, st, trk, (st == S_REC), kp, ki, fo};
  endfunction

  function automatic logic [63:0] obs_word();
    return {18'd0, bus.state, bus.locked, bus.lf_clr, bus.kp_shift, bus.ki_shift, bus.freq_offset};
  endfunction

  task automatic send(input logic [27:0] v);
    bus.err_valid = 1'b1;
    bus.err       = v;
    tick();
    bus.err_valid = 1'b0;
    bus.err       = 28'd0;
  endtask

  task automatic send_n(input logic [27:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(v);
      repeat (gap) tick();
    end
  endtask

  // One sample, with the same-cycle lf_ce checked before the clock edge.
  task automatic send_ce(input logic [27:0] v, input logic exp_ce, input string tag);
    bus.err_valid = 1'b1;
    bus.err       = v;
    push_exp(tag, {63'd0, exp_ce});
    #1;
    check_next({63'd0, bus.lf_ce});
    tick();
    bus.err_valid = 1'b0;
    bus.err       = 28'd0;
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st);
    push_exp(tag, st_word(st, exp_fo));
    check_next(obs_word());
  endtask

  task automatic expect_after_tick(input string tag, input logic [1:0] st);
    push_exp(tag, st_word(st, exp_fo));
    tick();
    check_next(obs_word());
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int k;
    k = 0;
    while ((bus.state !== st) && (k < budget)) begin
      tick();
      k++;
    end
    push_exp(tag, {62'd0, st});
    check_next({62'd0, bus.state});
  endtask

  function automatic logic [31:0] sweep_model(input logic [31:0] fo);
    logic [31:0] s;
    s = fo + 32'h0010_0000;
    if ($signed(s) > $signed(32'h0080_0000)) begin
      s = 32'hFF80_0000;
    end
    return s;
  endfunction

  initial begin
    bus.enable    = 1'b0;
    bus.err_valid = 1'b0;
    bus.err       = 28'd0;
    rst           = 1'b1;
    tick();
    tick();
    expect_now("reset", S_IDLE);
    rst = 1'b0;
    tick();
    expect_now("idle_hold", S_IDLE);
    send_ce(28'd0, 1'b0, "lf_ce_idle");

    // Acquire: filter clear for 4 clocks, then lock on the 64th good sample.
    bus.enable = 1'b1;
    expect_after_tick("enter_recover", S_REC);
    clr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.lf_clr !== 1'b1) break;
      clr_seen++;
      tick();
    end
    push_exp("clr_cycles", 64'd4);
    check_next(64'(clr_seen));
    expect_now("acq_after_clr", S_ACQ);
    send_ce(28'd0, 1'b1, "lf_ce_acq");
    repeat (13) tick();
    send_n(28'd0, 62, 13);
    expect_now("acq_63_good", S_ACQ);
    push_exp("lock_64", st_word(S_TRK, exp_fo));
    send(28'd0);
    check_next(obs_word());

    // Unlock needs 16 consecutive bad samples; good and mid-band samples restart the run.
    send_n(28'd900000, 15, 0);
    expect_now("track_15_bad", S_TRK);
    send(28'd0);
    send_n(28'd900000, 15, 0);
    expect_now("track_reset_by_good", S_TRK);
    send(28'd500000);
    send_n(28'd900000, 15, 0);
    expect_now("track_reset_by_band", S_TRK);
    push_exp("unlock_16", st_word(S_REC, exp_fo));
    send(28'd900000);
    check_next(obs_word());
    send_ce(28'd0, 1'b0, "lf_ce_recover");

    // Most negative error is a bad sample; lf_ce still follows err_valid in TRACK.
    wait_state("reacq", S_ACQ, 10);
    send_n(28'd0, 64, 0);
    expect_now("relock", S_TRK);
    send_ce(28'h800_0000, 1'b1, "lf_ce_maxneg");
    send_n(28'h800_0000, 14, 0);
    expect_now("maxneg_15", S_TRK);
    push_exp("maxneg_unlock", st_word(S_REC, exp_fo));
    send(28'h800_0000);
    check_next(obs_word());

    // Acquisition timeout after 4096 samples that are neither good nor bad.
    wait_state("acq_t3", S_ACQ, 10);
`ifdef COSTAS_FREQ_SWEEP_EN
    n_timeouts = 9;
`else
    n_timeouts = 2;
`endif
    for (int t = 0; t < n_timeouts; t++) begin
      send_n(28'd300000, 4095, 0);
      expect_now("acq_4095", S_ACQ);
`ifdef COSTAS_FREQ_SWEEP_EN
      exp_fo = sweep_model(exp_fo);
`endif
      push_exp("timeout", st_word(S_REC, exp_fo));
      send(28'd300000);
      check_next(obs_word());
      wait_state("acq_after_timeout", S_ACQ, 10);
    end
`ifdef COSTAS_FREQ_SWEEP_EN
    push_exp("sweep_wrap", 64'h0000_0000_FF80_0000);
    check_next({32'd0, bus.freq_offset});
`endif

    // Lock on the same sample as the timeout: lock wins, offset unchanged.
    send_n(28'd300000, 4032, 0);
    send_n(28'd0, 63, 0);
    expect_now("acq_4095_mixed", S_ACQ);
    push_exp("lock_beats_timeout", st_word(S_TRK, exp_fo));
    send(28'd0);
    check_next(obs_word());

    // enable=0 from TRACK and from RECOVER returns to IDLE next clock.
    bus.enable = 1'b0;
    exp_fo     = 32'd0;
    expect_after_tick("disable_track", S_IDLE);
    send_ce(28'd0, 1'b0, "lf_ce_disabled");
    bus.enable = 1'b1;
    expect_after_tick("reenter_recover", S_REC);
    tick();
    bus.enable = 1'b0;
    expect_after_tick("disable_recover", S_IDLE);

    // Synchronous reset mid-ACQ and mid-RECOVER.
    bus.enable = 1'b1;
    wait_state("acq_before_rst", S_ACQ, 10);
    send_n(28'd300000, 10, 0);
    rst = 1'b1;
    expect_after_tick("rst_mid_acq", S_IDLE);
    rst = 1'b0;
    expect_after_tick("recover_after_rst", S_REC);
    rst = 1'b1;
    expect_after_tick("rst_mid_recover", S_IDLE);
    bus.enable = 1'b0;
    rst        = 1'b0;
    expect_after_tick("idle_final", S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
